mps_op_sequencer: RTL and testbench
===================================

MPS_OP_SEQUENCER -- requirements
Module: mps_op_sequencer

Interface
REQ-001 Parameter P_T_MC, default 100000, gives the contactor actuation/settle dwell in clocks (1 ms at 100 MHz).
REQ-002 Parameter P_T_CHG_TO, default 500000000, gives the slow-charge timeout in clocks.
REQ-003 Parameter P_T_DIS_TO, default 500000000, gives the discharge timeout in clocks.
REQ-004 i_clk  in  1  system clock.
REQ-005 i_rst  in  1  reset, asynchronous, active-low.
REQ-006 i_op_on_flag  in  1  one-cycle start request for the OP-ON sequence.
REQ-007 i_op_off_flag  in  1  one-cycle start request for the OP-OFF sequence.
REQ-008 i_intl_flag  in  1  interlock; abort request, level.
REQ-009 i_dc_volt  in  16  DC-link ADC code, unsigned.
REQ-010 i_th_chg  in  16  charged threshold, unsigned.
REQ-011 i_th_dis  in  16  discharged threshold, unsigned.
REQ-012 o_op_on_fsm  out  4  OP-ON step code, registered.
REQ-013 o_op_off_fsm  out  4  OP-OFF step code, registered.
REQ-014 o_busy  out  1  high while either sequence is active.
REQ-015 o_fault  out  2  sticky flags: bit0 charge timeout, bit1 discharge timeout.

Function
REQ-016 ON step codes SHALL be: 0 IDLE; 1 DIS_OPEN; 5 SLOW_CHG; 6 CHG_WAIT; 9 MAIN_ON; 11 SLOW_OFF; 14 DONE; 15 FAIL.
REQ-017 OFF step codes SHALL be: 0 IDLE; 1 MAIN_OFF; 2 DISCHARGE; 3 DONE.
REQ-018 In IDLE with i_op_on_flag=1, the next cycle SHALL show o_op_on_fsm=1, and o_fault[0] SHALL clear.
REQ-019 DIS_OPEN, SLOW_CHG, MAIN_ON and SLOW_OFF SHALL each hold for exactly P_T_MC cycles, then advance: 1->5->6, 9->11->14.
REQ-020 CHG_WAIT SHALL advance to 9 on the first cycle with i_dc_volt >= i_th_chg; if P_T_CHG_TO cycles elapse first, it SHALL go to 15 and set o_fault[0].
REQ-021 DONE (14) and FAIL (15) SHALL hold for exactly 1 cycle, then return to 0.
REQ-022 In IDLE with i_op_off_flag=1 and i_op_on_flag=0, the next cycle SHALL show o_op_off_fsm=1, and o_fault[1] SHALL clear.
REQ-023 MAIN_OFF SHALL hold for P_T_MC cycles, then go to 2.
REQ-024 DISCHARGE SHALL go to 3 once P_T_MC cycles have elapsed and i_dc_volt <= i_th_dis.
REQ-025 If DISCHARGE reaches P_T_DIS_TO cycles, it SHALL go to 3 and set o_fault[1].
REQ-026 OFF DONE (3) SHALL hold for 1 cycle, then return to 0.
REQ-027 If i_op_on_flag and i_op_off_flag are asserted together in IDLE, ON SHALL win.
REQ-028 Flags arriving while o_busy=1 SHALL be ignored.
REQ-029 Only one sequence SHALL be active at a time; the inactive sequence's code SHALL read 0.
REQ-030 i_intl_flag=1 SHALL force both codes to 0 on the next edge, clear the timer, and drop o_busy, with no DONE/FAIL code emitted; o_fault SHALL be preserved.
REQ-031 i_intl_flag SHALL take priority over simultaneous start flags.
REQ-032 The timer SHALL be a 32-bit unsigned up-counter, cleared on every step change, and SHALL saturate (no wrap-around).
REQ-033 Threshold comparisons SHALL be unsigned 16-bit, inclusive.
REQ-034 o_busy SHALL be 1 exactly when either code is nonzero.

Reset
REQ-035 On i_rst=0, o_op_on_fsm=0, o_op_off_fsm=0, o_busy=0, o_fault=2'b00 and timer=0, asynchronously.
REQ-036 Reset mid-sequence SHALL abandon the sequence, with no DONE/FAIL emitted after release.
REQ-037 The first post-reset start SHALL require a fresh flag.

Structure
REQ-038 The ON/OFF step-code constants SHALL live in shared package mps_seq_pkg, shared with the system FSM.
REQ-039 Dwell/timeout counting SHALL be one sub-module, mps_seq_timer, with clear and saturate behaviour and a compare-to-limit output.
REQ-040 The two sequences SHALL be independent case-based FSMs sharing one timer instance.

Verification (P_T_MC=4, P_T_CHG_TO=P_T_DIS_TO=20, i_th_chg=1000, i_th_dis=50)
REQ-041 ON pulse with i_dc_volt=1200 -> codes 1(4 cycles), 5(4), 6(1), 9(4), 11(4), 14(1), then 0; o_fault=00.
REQ-042 ON pulse with i_dc_volt=500 held -> 6 for 20 cycles, then 15 for 1 cycle, then 0; o_fault[0]=1.
REQ-043 OFF pulse with i_dc_volt=30 -> 1(4), 2(4), 3(1), then 0; with i_dc_volt=100 held -> 2 for 20 cycles, then 3, o_fault[1]=1.
REQ-044 i_intl_flag pulse during code 9 -> code 0 next cycle, o_busy=0, no 14; ON and OFF asserted together in IDLE -> only o_op_on_fsm=1.
REQ-045 Reset asserted during CHG_WAIT -> all outputs 0 immediately; an OFF flag issued during ON busy -> ignored.

Source files
------------

// File: rtl/mps_seq_pkg.sv
// Shared step codes and timer helpers for the magnet power supply sequencers.
// The system-level FSM imports the same package, so step codes stay consistent.
package mps_seq_pkg;

  localparam int SEQ_TIMER_W = 32;

  // OP-ON step codes. The values are what the supervisory system reads back.
  typedef enum logic [3:0] {
    ON_IDLE     = 4'd0,
    ON_DIS_OPEN = 4'd1,
    ON_SLOW_CHG = 4'd5,
    ON_CHG_WAIT = 4'd6,
    ON_MAIN_ON  = 4'd9,
    ON_SLOW_OFF = 4'd11,
    ON_DONE     = 4'd14,
    ON_FAIL     = 4'd15
  } on_step_e;

  // OP-OFF step codes.
  typedef enum logic [3:0] {
    OFF_IDLE      = 4'd0,
    OFF_MAIN_OFF  = 4'd1,
    OFF_DISCHARGE = 4'd2,
    OFF_DONE      = 4'd3
  } off_step_e;

  // Bit positions inside the sticky fault vector.
  localparam int FAULT_CHG_BIT = 0;
  localparam int FAULT_DIS_BIT = 1;

  // True on the cycle in which 'limit' cycles will have elapsed in the current
  // step, given that the timer reads 0 on the first cycle of a step. The sum is
  // widened by one bit so a saturated count cannot wrap to zero.
  function automatic logic limit_reached(input logic [SEQ_TIMER_W-1:0] count,
                                         input logic [SEQ_TIMER_W-1:0] limit);
    return ({1'b0, count} + {{SEQ_TIMER_W{1'b0}}, 1'b1}) >= {1'b0, limit};
  endfunction

endpackage

// File: rtl/mps_seq_timer.sv
// Dwell/timeout counter shared by the OP-ON and OP-OFF sequences.
// Counts up from zero after every clear and sticks at all-ones instead of wrapping.
module mps_seq_timer
  import mps_seq_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic [SEQ_TIMER_W-1:0] i_limit,
  output logic [SEQ_TIMER_W-1:0] o_count,
  output logic                   o_hit
);

  localparam logic [SEQ_TIMER_W-1:0] COUNT_ONE = {{(SEQ_TIMER_W-1){1'b0}}, 1'b1};

  logic [SEQ_TIMER_W-1:0] count;

  // Saturating up-counter, cleared whenever the owning sequence changes step.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + COUNT_ONE;
    end
  end

  assign o_count = count;
  assign o_hit   = limit_reached(count, i_limit);

endmodule

// File: rtl/mps_op_sequencer.sv
// OP-ON / OP-OFF contactor sequencer for the magnet power supply DC link.
// Two independent step FSMs share one dwell/timeout timer; at most one of them
// is away from IDLE at any time, and the interlock drops both straight to IDLE.
module mps_op_sequencer
  import mps_seq_pkg::*;
#(
  parameter int unsigned P_T_MC     = 100000,
  parameter int unsigned P_T_CHG_TO = 500000000,
  parameter int unsigned P_T_DIS_TO = 500000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_op_on_flag,
  input  logic        i_op_off_flag,
  input  logic        i_intl_flag,
  input  logic [15:0] i_dc_volt,
  input  logic [15:0] i_th_chg,
  input  logic [15:0] i_th_dis,
  output logic [3:0]  o_op_on_fsm,
  output logic [3:0]  o_op_off_fsm,
  output logic        o_busy,
  output logic [1:0]  o_fault
);

  localparam logic [SEQ_TIMER_W-1:0] LIM_MC     = SEQ_TIMER_W'(P_T_MC);
  localparam logic [SEQ_TIMER_W-1:0] LIM_CHG_TO = SEQ_TIMER_W'(P_T_CHG_TO);
  localparam logic [SEQ_TIMER_W-1:0] LIM_DIS_TO = SEQ_TIMER_W'(P_T_DIS_TO);

  on_step_e  on_state,  on_next;
  off_step_e off_state, off_next;

  logic chg_fault, chg_fault_next;
  logic dis_fault, dis_fault_next;

  logic                   timer_clear;
  logic [SEQ_TIMER_W-1:0] timer_limit;
  logic [SEQ_TIMER_W-1:0] timer_count;
  logic                   timer_hit;
  logic                   mc_elapsed;

  logic on_idle;
  logic off_idle;
  logic charged;
  logic discharged;

  assign on_idle    = (on_state == ON_IDLE);
  assign off_idle   = (off_state == OFF_IDLE);
  assign charged    = (i_dc_volt >= i_th_chg);
  assign discharged = (i_dc_volt <= i_th_dis);

  // The timer compares against the timeout only in the two waiting steps; every
  // other step is a fixed contactor dwell.
  always_comb begin
    timer_limit = LIM_MC;
    if (on_state == ON_CHG_WAIT) begin
      timer_limit = LIM_CHG_TO;
    end else if (off_state == OFF_DISCHARGE) begin
      timer_limit = LIM_DIS_TO;
    end
  end

  // DISCHARGE watches the timeout through timer_hit, so the minimum dwell there
  // is taken from the raw count instead.
  assign mc_elapsed = limit_reached(timer_count, LIM_MC);

  // Restart the count on every step change, on interlock, and while fully idle,
  // so each step always starts timing from zero.
  assign timer_clear = i_intl_flag
                     || (on_next != on_state)
                     || (off_next != off_state)
                     || (on_idle && off_idle);

  mps_seq_timer u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (timer_clear),
    .i_limit (timer_limit),
    .o_count (timer_count),
    .o_hit   (timer_hit)
  );

  // OP-ON state and charge-timeout flag register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      on_state  <= ON_IDLE;
      chg_fault <= 1'b0;
    end else begin
      on_state  <= on_next;
      chg_fault <= chg_fault_next;
    end
  end

  // OP-ON next step: contactor dwells, wait for DC link charge, then one-cycle
  // DONE or FAIL. A start is accepted only while both sequences are idle.
  always_comb begin
    on_next        = on_state;
    chg_fault_next = chg_fault;
    if (i_intl_flag) begin
      on_next = ON_IDLE;
    end else begin
      case (on_state)
        ON_IDLE: begin
          if (off_idle && i_op_on_flag) begin
            on_next        = ON_DIS_OPEN;
            chg_fault_next = 1'b0;
          end
        end
        ON_DIS_OPEN: begin
          if (timer_hit) on_next = ON_SLOW_CHG;
        end
        ON_SLOW_CHG: begin
          if (timer_hit) on_next = ON_CHG_WAIT;
        end
        ON_CHG_WAIT: begin
          if (charged) begin
            on_next = ON_MAIN_ON;
          end else if (timer_hit) begin
            on_next        = ON_FAIL;
            chg_fault_next = 1'b1;
          end
        end
        ON_MAIN_ON: begin
          if (timer_hit) on_next = ON_SLOW_OFF;
        end
        ON_SLOW_OFF: begin
          if (timer_hit) on_next = ON_DONE;
        end
        ON_DONE: on_next = ON_IDLE;
        ON_FAIL: on_next = ON_IDLE;
        default: on_next = ON_IDLE;
      endcase
    end
  end

  // OP-OFF state and discharge-timeout flag register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      off_state <= OFF_IDLE;
      dis_fault <= 1'b0;
    end else begin
      off_state <= off_next;
      dis_fault <= dis_fault_next;
    end
  end

  // OP-OFF next step: open the main contactor, then wait for the DC link to
  // bleed down. A timeout still finishes through DONE but leaves the fault set.
  // A simultaneous ON request takes precedence over OFF.
  always_comb begin
    off_next       = off_state;
    dis_fault_next = dis_fault;
    if (i_intl_flag) begin
      off_next = OFF_IDLE;
    end else begin
      case (off_state)
        OFF_IDLE: begin
          if (on_idle && !i_op_on_flag && i_op_off_flag) begin
            off_next       = OFF_MAIN_OFF;
            dis_fault_next = 1'b0;
          end
        end
        OFF_MAIN_OFF: begin
          if (timer_hit) off_next = OFF_DISCHARGE;
        end
        OFF_DISCHARGE: begin
          if (mc_elapsed && discharged) begin
            off_next = OFF_DONE;
          end else if (timer_hit) begin
            off_next       = OFF_DONE;
            dis_fault_next = 1'b1;
          end
        end
        OFF_DONE: off_next = OFF_IDLE;
        default:  off_next = OFF_IDLE;
      endcase
    end
  end

  assign o_op_on_fsm  = on_state;
  assign o_op_off_fsm = off_state;
  assign o_busy       = !(on_idle && off_idle);

  always_comb begin
    o_fault                = 2'b00;
    o_fault[FAULT_CHG_BIT] = chg_fault;
    o_fault[FAULT_DIS_BIT] = dis_fault;
  end

endmodule

// File: tb/tb_mps_op_sequencer.sv
// Bench for mps_op_sequencer with short dwell/timeout parameters.
// Expected per-cycle step codes are built as whole-sequence traces from the
// step durations, then compared cycle by cycle on the falling clock edge.
module tb_mps_op_sequencer;

  localparam int T_MC = 4;
  localparam int T_TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        on_flag  = 1'b0;
  logic        off_flag = 1'b0;
  logic        intl     = 1'b0;
  logic [15:0] dc_volt  = 16'd0;
  logic [15:0] th_chg   = 16'd1000;
  logic [15:0] th_dis   = 16'd50;
  logic [3:0]  on_fsm;
  logic [3:0]  off_fsm;
  logic        busy;
  logic [1:0]  fault;

  int test_count = 0;
  int fail_count = 0;

  logic [3:0] q_on[$];
  logic [3:0] q_off[$];
  logic [1:0] q_fault[$];
  logic [1:0] model_fault = 2'b00;

  logic [15:0] on_volts[6]  = '{16'd500, 16'd999, 16'd1000, 16'd1001, 16'd1200, 16'd0};
  logic [15:0] off_volts[6] = '{16'd30, 16'd49, 16'd50, 16'd51, 16'd100, 16'd0};
  int          kind;
  int          abort_at;
  int          inject_at;
  logic [15:0] volt;

  mps_op_sequencer #(
    .P_T_MC     (T_MC),
    .P_T_CHG_TO (T_TO),
    .P_T_DIS_TO (T_TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_op_on_flag  (on_flag),
    .i_op_off_flag (off_flag),
    .i_intl_flag   (intl),
    .i_dc_volt     (dc_volt),
    .i_th_chg      (th_chg),
    .i_th_dis      (th_dis),
    .o_op_on_fsm   (on_fsm),
    .o_op_off_fsm  (off_fsm),
    .o_busy        (busy),
    .o_fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] e_on,
                             input logic [3:0] e_off, input logic [1:0] e_fault);
    logic [10:0] obs;
    logic [10:0] exp_v;
    obs   = {on_fsm, off_fsm, busy, fault};
    exp_v = {e_on, e_off, (e_on != 4'd0) || (e_off != 4'd0), e_fault};
    test_count++;
    assert (obs === exp_v)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: on/off/busy/fault got %0d/%0d/%b/%b, expected %0d/%0d/%b/%b",
             tag, on_fsm, off_fsm, busy, fault, e_on, e_off, exp_v[2], e_fault);
    end
  endtask

  task automatic push_step(input logic [3:0] c_on, input logic [3:0] c_off, input int n);
    for (int k = 0; k < n; k++) begin
      q_on.push_back(c_on);
      q_off.push_back(c_off);
      q_fault.push_back(model_fault);
    end
  endtask

  // ON: two contactor dwells, then either a one-cycle charge check and two more
  // dwells ending in DONE, or a full timeout ending in FAIL.
  task automatic build_on(input logic [15:0] v);
    model_fault[0] = 1'b0;
    push_step(4'd1, 4'd0, T_MC);
    push_step(4'd5, 4'd0, T_MC);
    if (v >= th_chg) begin
      push_step(4'd6, 4'd0, 1);
      push_step(4'd9, 4'd0, T_MC);
      push_step(4'd11, 4'd0, T_MC);
      push_step(4'd14, 4'd0, 1);
    end else begin
      push_step(4'd6, 4'd0, T_TO);
      model_fault[0] = 1'b1;
      push_step(4'd15, 4'd0, 1);
    end
    push_step(4'd0, 4'd0, 1);
  endtask

  // OFF: one dwell, then the discharge wait (minimum dwell or full timeout).
  task automatic build_off(input logic [15:0] v);
    model_fault[1] = 1'b0;
    push_step(4'd0, 4'd1, T_MC);
    if (v <= th_dis) begin
      push_step(4'd0, 4'd2, T_MC);
    end else begin
      push_step(4'd0, 4'd2, T_TO);
      model_fault[1] = 1'b1;
    end
    push_step(4'd0, 4'd3, 1);
    push_step(4'd0, 4'd0, 1);
  endtask

  // Runs one sequence from idle; optionally raises the interlock after check
  // 'abort_idx' and/or pulses the opposite start flag after check 'inject_idx'.
  task automatic applyStimulus(input string tag, input logic on_p, input logic off_p,
                               input logic [15:0] v, input int abort_idx, input int inject_idx);
    int ab;
    int inj;
    q_on.delete();
    q_off.delete();
    q_fault.delete();
    dc_volt = v;
    if (on_p) build_on(v);
    else if (off_p) build_off(v);
    ab  = abort_idx;
    inj = inject_idx;
    if (ab >= q_on.size() - 1) ab = -1;
    if (ab >= 0) begin
      q_on    = q_on[0:ab];
      q_off   = q_off[0:ab];
      q_fault = q_fault[0:ab];
      model_fault = q_fault[ab];
      push_step(4'd0, 4'd0, 1);
    end
    if (inj > q_on.size() - 2) inj = -1;
    on_flag  = on_p;
    off_flag = off_p;
    for (int i = 0; i < q_on.size(); i++) begin
      @(negedge clk);
      on_flag  = 1'b0;
      off_flag = 1'b0;
      intl     = 1'b0;
      checkOutput(tag, q_on[i], q_off[i], q_fault[i]);
      if (i == ab) intl = 1'b1;
      if (i == inj) begin
        if (on_p) off_flag = 1'b1;
        else on_flag = 1'b1;
      end
    end
    on_flag  = 1'b0;
    off_flag = 1'b0;
    intl     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset", 4'd0, 4'd0, 2'b00);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("idle_after_reset", 4'd0, 4'd0, 2'b00);
    end

    applyStimulus("on_charged", 1'b1, 1'b0, 16'd1200, -1, -1);
    applyStimulus("on_timeout", 1'b1, 1'b0, 16'd500, -1, -1);
    applyStimulus("on_at_threshold", 1'b1, 1'b0, 16'd1000, -1, -1);
    applyStimulus("off_discharged", 1'b0, 1'b1, 16'd30, -1, -1);
    applyStimulus("off_timeout", 1'b0, 1'b1, 16'd100, -1, -1);
    applyStimulus("off_at_threshold", 1'b0, 1'b1, 16'd50, -1, -1);
    applyStimulus("intl_in_main_on", 1'b1, 1'b0, 16'd1200, 2 * T_MC + 1, -1);
    applyStimulus("on_off_together", 1'b1, 1'b1, 16'd1200, -1, -1);
    applyStimulus("off_during_on_busy", 1'b1, 1'b0, 16'd1200, -1, 3);
    applyStimulus("on_during_off_busy", 1'b0, 1'b1, 16'd30, -1, 2);

    // Interlock together with a start request in idle: nothing starts.
    intl    = 1'b1;
    on_flag = 1'b1;
    @(negedge clk);
    intl    = 1'b0;
    on_flag = 1'b0;
    checkOutput("intl_beats_start", 4'd0, 4'd0, model_fault);

    // Reset while waiting for charge: outputs drop without waiting for an edge,
    // and nothing resumes after release.
    dc_volt = 16'd500;
    on_flag = 1'b1;
    @(negedge clk);
    on_flag = 1'b0;
    repeat (2 * T_MC + 2) @(negedge clk);
    checkOutput("chg_wait_before_reset", 4'd6, 4'd0, {model_fault[1], 1'b0});
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 4'd0, 4'd0, 2'b00);
    model_fault = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < T_TO + 5; i++) begin
      @(negedge clk);
      checkOutput("quiet_after_reset", 4'd0, 4'd0, 2'b00);
    end

    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 2));
      abort_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      inject_at = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : -1;
      if (kind == 1) begin
        volt = off_volts[$urandom_range(0, 5)];
        if (volt == 16'd0) volt = 16'($urandom_range(0, 65535));
        applyStimulus("rand_off", 1'b0, 1'b1, volt, abort_at, inject_at);
      end else begin
        volt = on_volts[$urandom_range(0, 5)];
        if (volt == 16'd0) volt = 16'($urandom_range(0, 65535));
        applyStimulus(kind == 0 ? "rand_on" : "rand_both", 1'b1, kind == 2, volt,
                      abort_at, inject_at);
      end
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
